// File: rtl/fetch_pc_controller_pkg.sv
// Shared fetch-stage definitions: sequencer states, next-pc selector codes
// and the reserved constants (bubble word, reset pc, interrupt vector slot).
package fetch_pc_controller_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      INT_VEC  = 2'd2,
      INT_JUMP = 2'd3
   } fetch_state_e;

   typedef enum logic [2:0] {
      SEL_HOLD     = 3'd0,
      SEL_INC      = 3'd1,
      SEL_BRANCH   = 3'd2,
      SEL_VEC_ADDR = 3'd3,
      SEL_VECTOR   = 3'd4
   } pc_sel_e;

   localparam logic [15:0] NOP_WORD     = 16'hA000;
   localparam logic [31:0] RESET_PC     = 32'd32;
   localparam logic [31:0] INT_VEC_ADDR = 32'd0;

endpackage

// File: rtl/fetch_pc_controller_pc_next_mux.sv
// Next program-counter selection: hold, increment, branch redirect,
// interrupt vector slot, or the zero-extended handler address read from memory.
module pc_next_mux
   import fetch_pc_controller_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INSTR_W = 16,
   parameter logic [ADDR_W-1:0] INT_VEC_ADDR_P = ADDR_W'(INT_VEC_ADDR)
) (
   input  pc_sel_e            sel_i,
   input  logic [ADDR_W-1:0]  pc_i,
   input  logic [ADDR_W-1:0]  branch_target_i,
   input  logic [INSTR_W-1:0] vector_i,
   output logic [ADDR_W-1:0]  pc_next_o
);

   always_comb begin
      pc_next_o = pc_i;
      case (sel_i)
         SEL_HOLD:     pc_next_o = pc_i;
         SEL_INC:      pc_next_o = pc_i + ADDR_W'(1);
         SEL_BRANCH:   pc_next_o = branch_target_i;
         SEL_VEC_ADDR: pc_next_o = INT_VEC_ADDR_P;
         SEL_VECTOR:   pc_next_o = {{(ADDR_W-INSTR_W){1'b0}}, vector_i};
         default:      pc_next_o = pc_i;
      endcase
   end

endmodule

// File: rtl/fetch_pc_controller.sv
// Fetch-stage sequencer: owns the pc, chooses fetched word or bubble for decode,
// and arbitrates stall > branch > interrupt, including the two-cycle vector fetch.
module fetch_pc_controller
   import fetch_pc_controller_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INSTR_W = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC_P     = ADDR_W'(RESET_PC),
   parameter logic [ADDR_W-1:0]  INT_VEC_ADDR_P = ADDR_W'(INT_VEC_ADDR),
   parameter logic [INSTR_W-1:0] NOP_WORD_P     = INSTR_W'(NOP_WORD)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               int_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  epc,
   output logic               int_ack
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   pc_sel_e           sel;
   logic              accept;

   pc_next_mux #(
      .ADDR_W         (ADDR_W),
      .INSTR_W        (INSTR_W),
      .INT_VEC_ADDR_P (INT_VEC_ADDR_P)
   ) u_pc_next_mux (
      .sel_i           (sel),
      .pc_i            (pc_q),
      .branch_target_i (branch_target),
      .vector_i        (imem_data),
      .pc_next_o       (pc_d)
   );

   // Only RUN forwards memory data; every other path presents a bubble.
   always_comb begin
      sel         = SEL_HOLD;
      state_d     = state_q;
      epc_d       = epc_q;
      instruction = NOP_WORD_P;
      accept      = 1'b0;
      case (state_q)
         RUN: begin
            if (stall) begin
               instruction = imem_data;
            end else if (branch_taken) begin
               sel     = SEL_BRANCH;
               state_d = FLUSH;
            end else if (int_req) begin
               accept  = 1'b1;
               epc_d   = pc_q;
               sel     = SEL_VEC_ADDR;
               state_d = INT_VEC;
            end else begin
               sel         = SEL_INC;
               instruction = imem_data;
            end
         end
         FLUSH: begin
            if (stall) begin
               sel = SEL_HOLD;
            end else if (branch_taken) begin
               sel = SEL_BRANCH;
            end else begin
               sel     = SEL_INC;
               state_d = RUN;
            end
         end
         INT_VEC: begin
            sel     = SEL_VECTOR;
            state_d = INT_JUMP;
         end
         INT_JUMP: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC_P;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign epc       = epc_q;
   assign int_ack   = accept & ~reset;

endmodule
